// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op codes, the mul/div FSM state
// encoding and the default datapath width.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO. Shift-add multiply and
// restoring divide share one double-width working register, one bit per clock.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              W2   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [W2-1:0]     work;
    logic [WIDTH-1:0]  opnd;
    logic              is_div;
    logic              res_neg;
    logic              rem_neg;

    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    trial;
    logic [W2-1:0]     work_nxt;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [W2-1:0] cond_neg_wide(input logic [W2-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg     = signed_op && in1[WIDTH-1];
    assign b_neg     = signed_op && in2[WIDTH-1];
    assign a_mag     = mag(in1, signed_op);
    assign b_mag     = mag(in2, signed_op);

    // Multiply: upper half accumulates, whole register shifts right consuming
    // multiplier bits. Divide: remainder in upper half, quotient shifts in at bit 0.
    always_comb begin
        sum   = {1'b0, work[W2-1:WIDTH]} + {1'b0, (work[0] ? opnd : {WIDTH{1'b0}})};
        trial = work[W2-1:WIDTH-1] - {1'b0, opnd};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                work_nxt = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            end else begin
                work_nxt = {work[W2-2:0], 1'b0};
            end
        end else begin
            work_nxt = {sum, work[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            work    <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                work    <= {{WIDTH{1'b0}}, b_mag};
                                opnd    <= a_mag;
                                is_div  <= 1'b0;
                                res_neg <= a_neg ^ b_neg;
                                rem_neg <= 1'b0;
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= MD_CALC;
                            end
                            MD_DIV, MD_DIVU: begin
                                work    <= {{WIDTH{1'b0}}, a_mag};
                                opnd    <= b_mag;
                                is_div  <= 1'b1;
                                // A zero divisor must leave the all-ones quotient unnegated.
                                res_neg <= (a_neg ^ b_neg) && (in2 != '0);
                                rem_neg <= a_neg;
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= MD_CALC;
                            end
                            MD_MTHI: hi <= in1;
                            MD_MTLO: lo <= in1;
                            default: ;
                        endcase
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                    end else begin
                        work <= work_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            lo <= cond_neg(work[WIDTH-1:0], res_neg);
                            hi <= cond_neg(work[W2-1:WIDTH], rem_neg);
                        end else begin
                            {hi, lo} <= cond_neg_wide(work, res_neg);
                        end
                        done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle MIPS multiply/divide responder that owns the HI/LO register pair.
- Serves mult, multu, div, divu, mthi and mtlo, which the single-cycle ALU path does not handle.
- Sits beside the ALU in the EX stage. The pipeline issues a request with start/op and operands, then stalls on busy; mfhi/mflo read hi/lo directly.
- Iterative: one partial-product or quotient bit per clock.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, request strobe; sampled only when busy=0.
- op, input, 3, operation code: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- in1, input, WIDTH, rs operand (multiplicand, dividend, or mthi/mtlo source).
- in2, input, WIDTH, rt operand (multiplier or divisor).
- flush, input, 1, synchronous abort of an in-flight operation.
- busy, output, 1, operation in progress; the pipeline stalls mfhi/mflo/md ops while high.
- done, output, 1, one-cycle pulse; hi/lo hold the new result in this cycle.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - busy=0, done=0, hi=0, lo=0.
  - Internal accumulators are cleared.
  - Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes: absolute value for signed ops, raw for unsigned ops.
  - Latch result-sign flags.
  - counter<=0, go to CALC; busy=1 from the next cycle.
- IDLE, start=1, op=MTHI/MTLO:
  - hi<=in1 (MTHI) or lo<=in1 (MTLO) at that edge.
  - No busy, no done.
- IDLE, start=1, op undefined: no effect.
- start while busy=1 is ignored; no queueing.
- CALC, multiply: shift-add, 1 multiplier bit per cycle, 64-bit accumulator.
- CALC, divide: restoring division on a 64-bit remainder/quotient register, 1 quotient bit per cycle.
- CALC runs exactly WIDTH cycles (counter 0..WIDTH-1), then goes to FIX.
- FIX (1 cycle):
  - Apply sign correction.
  - Write hi/lo, go to IDLE.
  - done=1 for the following cycle, with busy=0 in that cycle.
- Latency: start sampled at edge E0 → busy high for WIDTH+1 cycles → done and new hi/lo visible after edge E(WIDTH+1). Total 34 cycles for WIDTH=32.
- Multiply result:
  - {hi,lo} = full 2*WIDTH product.
  - Signed: product negated when the operand signs differ.
- Divide result:
  - lo=quotient, hi=remainder.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (all div ops): lo=all ones, hi=in1 as latched, no exception. CALC still runs the full length.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of magnitude arithmetic; no special case.
- flush=1 in CALC or FIX:
  - Next state IDLE, busy=0 from the next cycle.
  - No done; hi/lo unchanged.
- flush has priority over start in IDLE; the start is dropped.
- done is low whenever it is not the single post-FIX cycle.
- hi/lo change only on FIX, MTHI, MTLO or reset.

Decomposition:
- Shared package (mips_pkg) holds:
  - op codes MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5;
  - state encoding MD_IDLE/MD_CALC/MD_FIX;
  - the WIDTH constant.
- No sub-module is needed; the shift-add and restoring datapaths share one 64-bit working register inside mul_div_unit.

Test Plan:
- MULTU in1=0xFFFFFFFF, in2=0xFFFFFFFF → done 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT in1=-3, in2=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV in1=-7, in2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU in1=7, in2=0 → hi=7, lo=0xFFFFFFFF. DIV in1=0x80000000, in2=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI in1=0x12345678 while idle → hi=0x12345678 next cycle, busy and done stay 0. Then MULT with start re-asserted at cycle 5 of busy with different operands → second request ignored, first result delivered.
- DIVU 100/7 with flush=1 on the 10th busy cycle → busy=0 next cycle; no done; hi/lo keep their prior values. A new MULTU 6*7 then gives lo=42, hi=0.
- Reset asserted asynchronously mid-CALC → busy, done, hi, lo = 0 immediately. After release, MULTU 2*3 completes normally with lo=6.
